// File: rtl/sfx_sequencer_if.sv
// sfx_sequencer_if
//   Bundles the request/control inputs and the playback outputs of the
//   sound-effect sequencer.
//   master : event source / output stage side (drives req, enable, abort)
//   slave  : the sequencer itself
//   Signals:
//     req[3:0]    one-cycle request pulses ([0] win, [1] moo, [2] detect, [3] cheer)
//     enable      1 = run, 0 = pause tick counter and hold off new clips
//     abort       one-cycle pulse, stops the current clip
//     rom_addr    clip ROM address
//     sample_stb  one-cycle pulse per sample tick
//     play_sound  high while a clip is playing
//     busy        high when the sequencer is not idle
//     clip_id     index of the current/last clip
//     clip_done   one-cycle pulse on natural clip completion
//     pending     latched outstanding requests
interface sfx_sequencer_if #(
  parameter int unsigned ADDR_W = 18
) ();
  logic [3:0]        req;
  logic              enable;
  logic              abort;
  logic [ADDR_W-1:0] rom_addr;
  logic              sample_stb;
  logic              play_sound;
  logic              busy;
  logic [1:0]        clip_id;
  logic              clip_done;
  logic [3:0]        pending;

  modport master (
    output req, enable, abort,
    input  rom_addr, sample_stb, play_sound, busy, clip_id, clip_done, pending
  );

  modport slave (
    input  req, enable, abort,
    output rom_addr, sample_stb, play_sound, busy, clip_id, clip_done, pending
  );
endinterface

// File: rtl/sfx_sequencer.sv
// sfx_sequencer
//   Latches game-event requests, picks one by fixed priority
//   (win > moo > detect > cheer) and plays that clip once by walking the
//   shared clip ROM from its start to its end address, one address per
//   sample tick of TICK_DIV clocks.
//   Ports:
//     CLOCK_50  system clock
//     resetn    asynchronous active-low reset
//     bus       sfx_sequencer_if.slave (requests in, playback signals out)
module sfx_sequencer #(
  parameter int unsigned TICK_DIV    = 1200,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WIN_START   = 0,
  parameter int unsigned WIN_END     = 16395,
  parameter int unsigned MOO_START   = 16396,
  parameter int unsigned MOO_END     = 66982,
  parameter int unsigned DET_START   = 66983,
  parameter int unsigned DET_END     = 83254,
  parameter int unsigned CHEER_START = 83255,
  parameter int unsigned CHEER_END   = 137138
) (
  input logic           CLOCK_50,
  input logic           resetn,
  sfx_sequencer_if.slave bus
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        pending_q, pending_d;
  logic [3:0]        clr;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [1:0]        id_q, id_d;
  logic [1:0]        win_idx;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              tick_hit;

  function automatic logic [ADDR_W-1:0] clip_start(input logic [1:0] id);
    case (id)
      2'd0:    clip_start = ADDR_W'(WIN_START);
      2'd1:    clip_start = ADDR_W'(MOO_START);
      2'd2:    clip_start = ADDR_W'(DET_START);
      default: clip_start = ADDR_W'(CHEER_START);
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] clip_end(input logic [1:0] id);
    case (id)
      2'd0:    clip_end = ADDR_W'(WIN_END);
      2'd1:    clip_end = ADDR_W'(MOO_END);
      2'd2:    clip_end = ADDR_W'(DET_END);
      default: clip_end = ADDR_W'(CHEER_END);
    endcase
  endfunction

  // Lowest set pending bit wins.
  always_comb begin
    win_idx = 2'd0;
    if (pending_q[0])      win_idx = 2'd0;
    else if (pending_q[1]) win_idx = 2'd1;
    else if (pending_q[2]) win_idx = 2'd2;
    else if (pending_q[3]) win_idx = 2'd3;
  end

  assign start_addr = clip_start(win_idx);
  assign end_addr   = clip_end(id_q);

  // A sample tick needs a running counter; a paused counter sitting at the
  // last count does not strobe, and an abort cancels the tick.
  assign tick_hit = (state_q == S_PLAY) && bus.enable && !bus.abort &&
                    (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tick_d  = tick_q;
    id_d    = id_q;
    clr     = '0;

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        tick_d = '0;
        if (bus.enable && (pending_q != 4'b0000)) state_d = S_LOAD;
      end

      S_LOAD: begin
        // The request is consumed even if this cycle is aborted.
        id_d = win_idx;
        clr  = 4'b0001 << win_idx;
        tick_d = '0;
        if (bus.abort) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else begin
          state_d = S_PLAY;
          addr_d  = start_addr;
        end
      end

      S_PLAY: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          addr_d  = '0;
          tick_d  = '0;
        end else if (bus.enable) begin
          if (tick_hit) begin
            tick_d = '0;
            if (addr_q == end_addr) begin
              state_d = S_DONE;
              addr_d  = '0;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        addr_d  = '0;
        tick_d  = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
        tick_d  = '0;
      end
    endcase

    // A request arriving in the same cycle LOAD clears its bit keeps it set.
    pending_d = (pending_q & ~clr) | bus.req;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      addr_q    <= '0;
      tick_q    <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      tick_q    <= tick_d;
      id_q      <= id_d;
    end
  end

  always_comb begin
    bus.rom_addr   = addr_q;
    bus.sample_stb = tick_hit;
    bus.play_sound = (state_q == S_PLAY);
    bus.busy       = (state_q != S_IDLE);
    bus.clip_id    = id_q;
    bus.clip_done  = (state_q == S_DONE);
    bus.pending    = pending_q;
  end

endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
- Upstream of the audio output stage.
- Collects single-cycle game-event requests (win, moo, detect, cheer) and arbitrates them by fixed priority.
- Plays each selected clip exactly once by walking the shared clip ROM from the clip's start address to its end address, one address per sample tick.
- Drives play_sound, the ROM address and a per-sample strobe to the output stage, so that stage no longer hard-codes a single looping clip.

Parameters:
TICK_DIV, 1200, CLOCK_50 cycles per sample (50 MHz / 1200 ≈ 41.7 kHz); legal range ≥ 2
ADDR_W, 18, ROM address width
WIN_START, 0, first address of win clip
WIN_END, 16395, last address of win clip
MOO_START, 16396, first address of moo clip
MOO_END, 66982, last address of moo clip
DET_START, 66983, first address of detect clip
DET_END, 83254, last address of detect clip
CHEER_START, 83255, first address of cheer clip
CHEER_END, 137138, last address of cheer clip

Ports:
CLOCK_50  input  1  system clock
resetn  input  1  asynchronous active-low reset
req  input  4  one-cycle request pulses: [0] win, [1] moo, [2] detect, [3] cheer
enable  input  1  1 = run; 0 = pause the tick counter and do not start new clips
abort  input  1  one-cycle pulse; stops the current clip immediately
rom_addr  output  ADDR_W  clip ROM address
sample_stb  output  1  one-cycle pulse per sample tick
play_sound  output  1  high while a clip is playing
busy  output  1  high when not IDLE
clip_id  output  2  index of the current/last clip (0 win, 1 moo, 2 detect, 3 cheer)
clip_done  output  1  one-cycle pulse when a clip completes naturally
pending  output  4  latched outstanding requests

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, pending=0, rom_addr=0, tick counter=0, clip_id=0.
  - sample_stb, play_sound, busy and clip_done all 0.
- Request latch, every cycle:
  - pending <= (pending & ~clr) | req, where clr is the bit cleared by LOAD.
  - If req sets the same bit in the cycle LOAD clears it, set wins; the request stays pending.
  - A request for the clip currently playing re-latches and replays after the current clip.
- Arbitration: fixed priority, win > moo > detect > cheer (lowest index wins).
- FSM states: IDLE, LOAD, PLAY, DONE.
  - IDLE: rom_addr=0, play_sound=0. If enable=1 and pending≠0, go to LOAD next cycle.
  - LOAD (1 cycle): clip_id <= winning index; clear that pending bit; rom_addr <= clip start; tick counter <= 0; go to PLAY.
  - PLAY: play_sound=1.
    - Tick counter increments each cycle while enable=1 and holds while enable=0 (pause). rom_addr is held during a pause.
    - When the counter = TICK_DIV-1: sample_stb=1 for that cycle and the counter returns to 0.
    - On that tick, if rom_addr = clip end, go to DONE; otherwise rom_addr <= rom_addr+1.
  - DONE (1 cycle): clip_done=1, play_sound=0, rom_addr=0. Go to IDLE.
- Latency and address timing:
  - A req pulse in cycle n gives pending set in cycle n+1, LOAD in cycle n+2, PLAY from cycle n+3.
  - The first sample_stb occurs TICK_DIV cycles after PLAY entry.
  - rom_addr changes only in the cycle after a sample_stb. The address is therefore stable for TICK_DIV cycles, which covers the 1-cycle ROM read latency.
- Sample count: a clip of length L = end-start+1 produces exactly L sample_stb pulses. busy=1 from LOAD through DONE inclusive.
- Abort:
  - In LOAD or PLAY: next state is IDLE; rom_addr=0; tick counter=0; no clip_done pulse. pending is unaffected, apart from LOAD's own clear.
  - In IDLE or DONE: abort is ignored.
- Reset mid-clip: state returns to IDLE immediately, all pending requests are lost, and no clip_done pulse is produced.
- Arithmetic: all addresses are ADDR_W unsigned. No wrap-around is possible because the end addresses are below 2^ADDR_W.

Test Plan:
Use parameter overrides TICK_DIV=4, WIN=0..3, MOO=4..9, DET=10..11, CHEER=12..15 unless stated otherwise.
1. Single req[1] pulse, enable=1 -> pending=0010 next cycle; LOAD; rom_addr 4,5,…,9 with sample_stb every 4 cycles (6 strobes); clip_done once; rom_addr=0 and busy=0 afterwards.
2. req=1100 in one cycle -> detect plays first (addr 10,11, clip_id=2), then cheer (12..15, clip_id=3); pending goes 1100 -> 1000 -> 0000.
3. Apply abort during PLAY at rom_addr=6 -> next cycle IDLE, rom_addr=0, play_sound=0, no clip_done; a pending req[0] then starts win (addr 0..3).
4. enable=0 for 10 cycles mid-clip -> no sample_stb and rom_addr held; on resume, the strobe spacing matches the counter position held before the pause.
5. Assert req[0] in the same cycle LOAD clears bit 0 -> pending[0] remains 1 and win replays after the current clip.
6. Drive resetn=0 asynchronously during PLAY (between clock edges) -> all outputs 0 immediately; after release, stays IDLE with no strobes until a new req.
